// File: rtl/hazard_ctrl.sv
// Pipeline hazard/halt controller: load-use stalls, branch flushes, memory freezes, halt drain with watchdog.
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int DRAIN_MAX = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idex_memread,
  input  logic [3:0]       idex_rt,
  input  logic [3:0]       ifid_rs,
  input  logic [3:0]       ifid_rt,
  input  logic             ifid_uses_rs,
  input  logic             ifid_uses_rt,
  input  logic             ifid_hlt,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             memwb_hlt,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             ifid_flush,
  output logic             idex_wen,
  output logic             idex_bubble,
  output logic             exmem_wen,
  output logic             memwb_wen,
  output logic             halted,
  output logic             halt_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;
  localparam int DW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

  logic [1:0]    state, state_d;
  logic [DW-1:0] drain_cnt, drain_cnt_d;
  logic          err_q, err_d;
  logic          load_use, stall_ev;

  // x0 is hardwired zero, so a load targeting it can never feed a consumer
  assign load_use = idex_memread && (idex_rt != 4'd0) &&
                    ((ifid_uses_rs && (ifid_rs == idex_rt)) ||
                     (ifid_uses_rt && (ifid_rt == idex_rt)));

  always_comb begin
    pc_wen      = 1'b1;
    ifid_wen    = 1'b1;
    ifid_flush  = 1'b0;
    idex_wen    = 1'b1;
    idex_bubble = 1'b0;
    exmem_wen   = 1'b1;
    memwb_wen   = 1'b1;
    stall_ev    = 1'b0;
    state_d     = state;
    drain_cnt_d = drain_cnt;
    err_d       = err_q;
    if (rst) begin
      state_d = RUN;
    end else if (state == HALTED) begin
      pc_wen    = 1'b0;
      ifid_wen  = 1'b0;
      idex_wen  = 1'b0;
      exmem_wen = 1'b0;
      memwb_wen = 1'b0;
    end else if (mem_busy) begin
      pc_wen    = 1'b0;
      ifid_wen  = 1'b0;
      idex_wen  = 1'b0;
      exmem_wen = 1'b0;
      memwb_wen = 1'b0;
      stall_ev  = 1'b1;
    end else if (state == DRAIN) begin
      pc_wen     = 1'b0;
      ifid_flush = 1'b1;
      if (memwb_hlt) begin
        state_d = HALTED;
      end else if (drain_cnt == DW'(DRAIN_MAX - 1)) begin
        state_d = HALTED;
        err_d   = 1'b1;
      end else begin
        drain_cnt_d = drain_cnt + DW'(1);
      end
    end else if (load_use) begin
      pc_wen      = 1'b0;
      ifid_wen    = 1'b0;
      idex_bubble = 1'b1;
      stall_ev    = 1'b1;
    end else if (ifid_hlt) begin
      pc_wen      = 1'b0;
      state_d     = DRAIN;
      drain_cnt_d = '0;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_d;
      drain_cnt <= drain_cnt_d;
      err_q     <= err_d;
    end
  end

  assign halted   = (state == HALTED) && !rst;
  assign halt_err = err_q && !rst;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] sc_q, fc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q <= '0;
      fc_q <= '0;
    end else if (state != HALTED) begin
      if (stall_ev && !(&sc_q))   sc_q <= sc_q + CNT_W'(1);
      if (ifid_flush && !(&fc_q)) fc_q <= fc_q + CNT_W'(1);
    end
  end

  assign stall_cycles = rst ? '0 : sc_q;
  assign flush_count  = rst ? '0 : fc_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle comparison against a behavioural model plus literal spot checks.
module tb_hazard_ctrl;
  localparam int CNT_W = 16;
  localparam int DMAX  = 8;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic idex_memread, ifid_uses_rs, ifid_uses_rt, ifid_hlt, branch_taken, mem_busy, memwb_hlt;
  logic [3:0] idex_rt, ifid_rs, ifid_rt;
  logic pc_wen, ifid_wen, ifid_flush, idex_wen, idex_bubble, exmem_wen, memwb_wen, halted, halt_err;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int checks = 0;
  int failures = 0;

  hazard_ctrl #(.DRAIN_MAX(DMAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rs(ifid_uses_rs), .ifid_uses_rt(ifid_uses_rt),
    .ifid_hlt(ifid_hlt), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .memwb_hlt(memwb_hlt),
    .pc_wen(pc_wen), .ifid_wen(ifid_wen), .ifid_flush(ifid_flush),
    .idex_wen(idex_wen), .idex_bubble(idex_bubble),
    .exmem_wen(exmem_wen), .memwb_wen(memwb_wen),
    .halted(halted), .halt_err(halt_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Model: mode 0=run 1=drain 2=halted; drain_seen counts unfrozen drain cycles
  int m_mode = 0, drain_seen = 0, m_sc = 0, m_fc = 0;
  bit m_err = 1'b0;

  always @(negedge clk) begin : cmp
    logic lu;
    logic [8:0] e, a;
    int esc, efc;
    lu = idex_memread && idex_rt != 4'd0 &&
         ((ifid_uses_rs && ifid_rs == idex_rt) || (ifid_uses_rt && ifid_rt == idex_rt));
    // {pc, ifid, flush, idex, bubble, exmem, memwb, halted, err}
    if (rst)              e = 9'b11_0_1_0_11_00;
    else if (m_mode == 2) e = {7'b00_0_0_0_00, 1'b1, m_err};
    else if (mem_busy)    e = {7'b00_0_0_0_00, 1'b0, m_err};
    else if (m_mode == 1) e = {7'b01_1_1_0_11, 1'b0, m_err};
    else if (lu)          e = 9'b00_0_1_1_11_00;
    else if (ifid_hlt)    e = 9'b01_0_1_0_11_00;
    else if (branch_taken) e = 9'b11_1_1_0_11_00;
    else                  e = 9'b11_0_1_0_11_00;
    a = {pc_wen, ifid_wen, ifid_flush, idex_wen, idex_bubble, exmem_wen, memwb_wen, halted, halt_err};
    esc = (rst || !PERF) ? 0 : m_sc;
    efc = (rst || !PERF) ? 0 : m_fc;
    chk("model_outputs", {23'd0, a}, {23'd0, e});
    chk("model_stall_cycles", {16'd0, stall_cycles}, esc);
    chk("model_flush_count", {16'd0, flush_count}, efc);
    if (rst) begin
      m_mode = 0; drain_seen = 0; m_err = 1'b0; m_sc = 0; m_fc = 0;
    end else if (m_mode != 2) begin
      if (mem_busy) m_sc = (m_sc < 65535) ? m_sc + 1 : m_sc;
      else if (m_mode == 1) begin
        m_fc = (m_fc < 65535) ? m_fc + 1 : m_fc;
        drain_seen++;
        if (memwb_hlt) m_mode = 2;
        else if (drain_seen == DMAX) begin m_mode = 2; m_err = 1'b1; end
      end else if (lu) m_sc = (m_sc < 65535) ? m_sc + 1 : m_sc;
      else if (ifid_hlt) begin m_mode = 1; drain_seen = 0; end
      else if (branch_taken) m_fc = (m_fc < 65535) ? m_fc + 1 : m_fc;
    end
  end

  task automatic idle();
    idex_memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    ifid_uses_rs = 0; ifid_uses_rt = 0; ifid_hlt = 0;
    branch_taken = 0; mem_busy = 0; memwb_hlt = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_lu(input logic [3:0] rt, input logic [3:0] rs);
    idex_memread = 1; idex_rt = rt; ifid_rs = rs; ifid_uses_rs = 1;
  endtask

  function automatic logic [4:0] wens();
    return {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen};
  endfunction

  initial begin
    idle(); rst = 1;
    #1;
    chk("reset_wens", wens(), 5'b11111);
    tick(); tick();
    chk("reset_halted", halted, 0);
    rst = 0;

    set_lu(4'd3, 4'd3); #1;
    chk("lu_wens", wens(), 5'b00111);
    chk("lu_bubble", idex_bubble, 1);
    tick(); idle(); #1;
    chk("after_lu_wens", wens(), 5'b11111);

    set_lu(4'd0, 4'd0); #1;
    chk("x0_no_stall", {wens(), idex_bubble}, 6'b111110);
    tick(); idle();
    idex_memread = 1; idex_rt = 5; ifid_rt = 5; ifid_uses_rt = 1; #1;
    chk("lu_rt_path", {pc_wen, idex_bubble}, 2'b01);
    tick(); idle();
    idex_memread = 1; idex_rt = 6; ifid_rs = 6; ifid_uses_rs = 0; #1;
    chk("unused_rs_no_stall", pc_wen, 1);
    tick(); idle();

    branch_taken = 1; #1;
    chk("branch_flush", ifid_flush, 1);
    tick(); idle(); #1;
    chk("branch_flush_one_cycle", ifid_flush, 0);
    if (PERF) chk("flush_count_one", flush_count, 1);

    // load-use with hlt pending: stall wins, still RUN next cycle
    set_lu(4'd2, 4'd2); ifid_hlt = 1; tick(); idle();

    ifid_hlt = 1; branch_taken = 1; #1;
    chk("hlt_entry", {pc_wen, ifid_flush}, 2'b00);
    tick(); idle(); set_lu(4'd4, 4'd4); branch_taken = 1; #1;
    chk("drain_ignores_lu", {wens(), ifid_flush, idex_bubble}, 7'b0111110);
    tick(); idle(); tick();
    memwb_hlt = 1; tick(); idle(); #1;
    chk("halted_after_drain", {halted, halt_err, wens()}, 7'b1000000);
    mem_busy = 1; #1;
    chk("halted_ignores_busy", {halted, ifid_flush}, 2'b10);
    tick(); idle(); rst = 1; tick(); rst = 0;

    // freeze inside drain, then memwb_hlt
    ifid_hlt = 1; tick(); idle(); tick();
    mem_busy = 1; #1;
    chk("drain_freeze", {wens(), ifid_flush}, 6'b000000);
    repeat (4) tick();
    mem_busy = 0; tick(); tick();
    memwb_hlt = 1; tick(); idle(); #1;
    chk("freeze_drain_halt", {halted, halt_err}, 2'b10);
    rst = 1; tick(); rst = 0;

    // watchdog: 3 unfrozen, 3 frozen, then 5 unfrozen
    ifid_hlt = 1; tick(); idle();
    repeat (3) tick();
    mem_busy = 1; repeat (3) tick(); mem_busy = 0;
    repeat (4) tick();
    chk("watchdog_not_yet", {halted, pc_wen, ifid_flush}, 3'b001);
    tick();
    chk("watchdog_fired", {halted, halt_err}, 2'b11);
    rst = 1; #1;
    chk("rst_masks_halted", {halted, halt_err}, 2'b00);
    tick(); rst = 0;

    // freeze beats load-use and branch
    set_lu(4'd7, 4'd7); branch_taken = 1; mem_busy = 1; #1;
    chk("freeze_priority", {wens(), ifid_flush, idex_bubble}, 7'b0);
    tick(); idle();
    if (PERF) chk("stall_after_freeze", stall_cycles, 1);
    ifid_hlt = 1; tick(); idle(); memwb_hlt = 1; tick(); idle(); #1;
    chk("halted_again", halted, 1);
    rst = 1; tick(); rst = 0; #1;
    chk("post_rst_run", {halted, wens()}, 6'b011111);
    chk("post_rst_counters", {stall_cycles, flush_count}, 32'd0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and halt controller; sits in the ID stage directly upstream of the ID/EX buffer.
- Drives the ID/EX buffer's write-enable (its `stall` input, active-high = capture) and its bubble/zero-control path.
- Also drives PC, IF/ID, EX/MEM and MEM/WB enables, the IF/ID flush, and the halt-drain sequence.
- Detects load-use hazards, taken-branch flushes, memory-busy freezes, and halt draining, with a watchdog on the drain.

Parameters:
- DRAIN_MAX, 8, max unfrozen cycles in DRAIN before forcing HALTED with halt_err.
- CNT_W, 16, width of performance counters (optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- idex_memread  in  1  instruction in EX is a load.
- idex_rt  in  4  destination reg of load in EX.
- ifid_rs  in  4  source reg 1 of instruction in ID.
- ifid_rt  in  4  source reg 2 of instruction in ID.
- ifid_uses_rs  in  1  ID instruction reads rs.
- ifid_uses_rt  in  1  ID instruction reads rt.
- ifid_hlt  in  1  ID instruction is HLT.
- branch_taken  in  1  branch in ID resolved taken.
- mem_busy  in  1  data/instr memory not ready; freeze whole pipe.
- memwb_hlt  in  1  HLT has reached MEM/WB.
- pc_wen  out  1  PC write-enable.
- ifid_wen  out  1  IF/ID write-enable.
- ifid_flush  out  1  IF/ID loads NOP.
- idex_wen  out  1  ID/EX write-enable.
- idex_bubble  out  1  ID/EX captures zeroed control (NOP).
- exmem_wen  out  1  EX/MEM write-enable.
- memwb_wen  out  1  MEM/WB write-enable.
- halted  out  1  core stopped.
- halt_err  out  1  drain watchdog expired.
- stall_cycles  out  CNT_W  load-use + freeze cycle count.
- flush_count  out  CNT_W  IF/ID flush count.

Behaviour:
- Outputs are combinational from registered state and current inputs (0-cycle latency). State is registered.
- FSM states: RUN, DRAIN, HALTED. Reset state is RUN; drain counter = 0; halt_err = 0.
- While rst=1: all wen = 1, ifid_flush = 0, idex_bubble = 0, halted = 0, halt_err = 0, counters = 0.
- Priority (highest first): rst > HALTED > mem_busy freeze > load-use > halt entry > branch flush.
- Defaults, unless overridden below: all wen = 1, flush = 0, bubble = 0.
- HALTED:
  - All wen = 0, halted = 1.
  - Held until rst; mem_busy and all other inputs ignored.
- Freeze (mem_busy=1, any state except HALTED):
  - All wen = 0, flush = 0, bubble = 0.
  - No state change; drain counter holds.
- Load-use condition (RUN only): idex_memread & idex_rt != 0 & ((ifid_uses_rs & ifid_rs == idex_rt) | (ifid_uses_rt & ifid_rt == idex_rt)).
  - Response: pc_wen = 0, ifid_wen = 0, idex_bubble = 1 (idex_wen stays 1).
  - branch_taken and ifid_hlt are ignored that cycle; they re-evaluate next cycle.
- Halt entry (RUN, ifid_hlt=1, no load-use):
  - pc_wen = 0; HLT is captured into ID/EX.
  - Next state DRAIN; drain counter cleared.
- Branch (RUN, branch_taken=1, no load-use, no hlt): ifid_flush = 1.
- DRAIN, per unfrozen cycle:
  - pc_wen = 0, ifid_wen = 1, ifid_flush = 1; downstream wen = 1.
  - branch_taken, load-use and ifid_hlt are ignored.
  - memwb_hlt=1 → HALTED.
  - Otherwise the counter increments; when the counter == DRAIN_MAX-1 and memwb_hlt=0, next state is HALTED with halt_err = 1.
- Register x0 (idex_rt == 0) never causes a load-use stall.
- Reset asserted mid-DRAIN or mid-freeze returns to RUN the next edge with no residual state.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: stall_cycles increments on each load-use or freeze cycle; flush_count increments on each cycle ifid_flush = 1. Both saturate at all-ones, are cleared by rst, and are frozen in HALTED.
- Undefined: no counter registers exist; both ports are driven constant 0.

Test Plan:
- Load x3, then add using x3 as rs (idex_memread=1, idex_rt=3, ifid_rs=3, uses_rs=1) → one cycle with pc_wen=0, ifid_wen=0, idex_bubble=1; next cycle all wen = 1.
- Same as above but idex_rt=0 and ifid_rs=0 → no stall, all wen = 1.
- branch_taken=1 in RUN → ifid_flush=1 for exactly 1 cycle; with PERF on, flush_count = 1.
- ifid_hlt=1, then memwb_hlt=1 three cycles later → DRAIN for 3 cycles with pc_wen=0 and ifid_flush=1, then halted=1 with all wen = 0; halt_err = 0.
- mem_busy=1 for 4 cycles during DRAIN, then memwb_hlt after 2 more cycles → counter holds during freeze, halted with halt_err = 0. Separately, no memwb_hlt with DRAIN_MAX=8 → halted and halt_err = 1 after 8 unfrozen DRAIN cycles.
- Load-use, branch_taken and mem_busy all asserted in one cycle → freeze wins (all wen = 0, flush = 0); with PERF on, stall_cycles +1. Then rst asserted in HALTED → next cycle RUN, halted = 0, counters = 0.
